aes_inv_mix_columns_seq: RTL and testbench
==========================================

Name: aes_inv_mix_columns_seq

Overview:
- Iterative AES InvMixColumns over a full 128-bit state, for the decryption round datapath.
- Processes COLS_PER_CYCLE columns per clock, internally registered.
- Valid/ready handshake on both sides, so it can sit between InvShiftRows/InvSubBytes and AddRoundKey stages that may stall.

Parameters:
- COLS_PER_CYCLE, 1: columns transformed per clock. Legal values 1, 2, 4. Any other value is a synthesis-time error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  din carries a state to transform
- in_ready  output  1  block can accept a state this cycle
- din  input  128  state; column c = din[127-32c -: 32]; within a column, byte [31:24] is row 0 and [7:0] is row 3
- out_valid  output  1  dout holds a finished result
- out_ready  input  1  downstream accepts dout this cycle
- dout  output  128  transformed state, same byte/column layout as din

Behaviour:
- Reset is asynchronous and active-high: rst=1 immediately forces state IDLE, in_ready=0 while rst is asserted, out_valid=0, dout=0, column counter=0, working register=0.
- in_ready=1 from the first clock after rst deasserts (state IDLE).
- Arithmetic, GF(2^8) mod x^8+x^4+x^3+x+1:
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00), full 8-bit constant.
  - Multiplies by 09/0b/0d/0e are built from three xtime stages plus XOR. No lookup tables.
- Per column a0..a3 (row 0..3):
  - r0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - r1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - r2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - r3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready at edge T, latch din into the working register, clear col counter → CALC. Otherwise stay.
  - CALC: in_ready=0, out_valid=0. Each edge replaces columns [cnt .. cnt+COLS_PER_CYCLE-1] in place with their transformed values; cnt += COLS_PER_CYCLE.
  - CALC exit: when the last group is written (cnt reaches 4 - COLS_PER_CYCLE), go to DONE on that same edge.
  - CALC length: 4/COLS_PER_CYCLE edges (4, 2 or 1).
  - DONE: out_valid=1, dout = working register, held stable while out_ready=0 (no change to dout or out_valid).
  - DONE exit: on out_valid&out_ready → IDLE next edge; out_valid drops and in_ready rises in the same cycle.
- Latency: accept edge T → out_valid high after edge T + 4/COLS_PER_CYCLE.
- Throughput: one state per 4/COLS_PER_CYCLE + 2 cycles when out_ready is held high.
- No input/output overlap: in_valid while not in IDLE is ignored. din is sampled only at the accept edge; din changes after acceptance have no effect.
- dout outside DONE: holds the last completed result; after reset it is 0. Bench checks dout only while out_valid=1.
- rst asserted mid-CALC or in DONE: in-flight state discarded, no output produced; behaviour as at reset.
- Wrap-around: cnt is 2 bits, wraps to 0 on the transition to DONE; never used out of range.

Test Plan:
- FIPS-197 column vectors, din=128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, in_valid=1, out_ready=1, COLS_PER_CYCLE=1 → dout=128'hdb135345_f20a225c_01010101_d4d4d4d5. out_valid rises exactly 4 cycles after the accept edge, for one cycle; in_ready low for 5 cycles.
- Same vectors with COLS_PER_CYCLE=2 and 4 → identical dout; latency 2 and 1 respectively.
- Round trip: din=128'h4d7ebdf8_c6c6c6c6_8e4da1bc_00000000 → dout=128'h2d26314c_c6c6c6c6_db135345_00000000. Zero column stays zero; c6c6c6c6 is a fixed point.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, dout constant, in_ready=0 throughout, and a second in_valid pulse is not accepted. Raise out_ready → IDLE next cycle.
- Reset mid-operation: assert rst asynchronously (between edges) during the 2nd CALC cycle → out_valid=0 and dout=0 immediately, no stale output ever appears. After release, a fresh state completes correctly.
- Back-to-back: in_valid and out_ready held high, 3 random states → 3 results in order, matching a software InvMixColumns model. Also check MixColumns(result) == input.

Source files
------------

// File: rtl/aes_inv_mix_columns_seq.sv
// Iterative AES InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
// Valid/ready on both sides; one state in flight at a time.
module aes_inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output logic [1:0]   dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // the source holds data and valid stable until then, ready never waits on valid.

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("aes_inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // STEP truncates 4 to 0; with four columns per cycle LAST is 0 so STEP is never used.
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    logic [1:0]   state;
    logic [1:0]   cnt;
    logic         armed;
    logic [127:0] work;
    logic [127:0] work_next;
    logic [1:0]   idx;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul_0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul_0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul_0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        r0 = mul_0e(a0) ^ mul_0b(a1) ^ mul_0d(a2) ^ mul_09(a3);
        r1 = mul_09(a0) ^ mul_0e(a1) ^ mul_0b(a2) ^ mul_0d(a3);
        r2 = mul_0d(a0) ^ mul_09(a1) ^ mul_0e(a2) ^ mul_0b(a3);
        r3 = mul_0b(a0) ^ mul_0d(a1) ^ mul_09(a2) ^ mul_0e(a3);
        return {r0, r1, r2, r3};
    endfunction

    // Column 0 occupies the most significant word.
    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] i);
        logic [31:0] c;
        case (i)
            2'd0:    c = s[127:96];
            2'd1:    c = s[95:64];
            2'd2:    c = s[63:32];
            default: c = s[31:0];
        endcase
        return c;
    endfunction

    function automatic logic [127:0] set_col(input logic [127:0] s, input logic [1:0] i,
                                             input logic [31:0] c);
        logic [127:0] r;
        r = s;
        case (i)
            2'd0:    r[127:96] = c;
            2'd1:    r[95:64]  = c;
            2'd2:    r[63:32]  = c;
            default: r[31:0]   = c;
        endcase
        return r;
    endfunction

    always_comb begin
        work_next = work;
        idx       = cnt;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            idx       = cnt + 2'(g);
            work_next = set_col(work_next, idx, inv_mix_col(get_col(work, idx)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
            armed <= 1'b0;
            work  <= '0;
            dout  <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        work  <= din;
                        cnt   <= 2'd0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    work <= work_next;
                    if (cnt == LAST) begin
                        cnt   <= 2'd0;
                        dout  <= work_next;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + STEP;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // armed keeps in_ready low until the first clock edge after reset releases.
    assign in_ready  = (state == S_IDLE) && armed;
    assign out_valid = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_aes_inv_mix_columns_seq.sv
// Directed bench for aes_inv_mix_columns_seq: vector table, latency for 1/2/4 columns
// per cycle, backpressure, asynchronous reset mid-operation and back-to-back states.
module tb_aes_inv_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic [2:0]   iv;
    logic [2:0]   ir;
    logic [2:0]   ov;
    logic [127:0] din;
    logic         ordy;
    logic [127:0] dout0, dout1, dout2;
    logic [1:0]   dbg0, dbg1, dbg2;

    int n_checks;
    int n_fail;

    logic [127:0] exp_q[$];
    logic [127:0] in_q[$];

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
        string        name;
    } vec_t;

    vec_t vecs[3];

    aes_inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .din(din),
        .out_valid(ov[0]), .out_ready(ordy), .dout(dout0), .dbg_state(dbg0)
    );
    aes_inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .din(din),
        .out_valid(ov[1]), .out_ready(ordy), .dout(dout1), .dbg_state(dbg1)
    );
    aes_inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .din(din),
        .out_valid(ov[2]), .out_ready(ordy), .dout(dout2), .dbg_state(dbg2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: generic shift-and-add GF(2^8) multiply
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model_col_mix(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        logic [7:0] a [4];
        logic [7:0] k [4];
        if (inv) begin k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09; end
        else     begin k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01; end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc;
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(k[(j - row + 4) % 4], a[j]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] dsel(input int u);
        case (u)
            0:       return dout0;
            1:       return dout1;
            default: return dout2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: one state through unit u with out_ready already high
    task automatic run_vec(input int u, input logic [127:0] d, input logic [127:0] e,
                           input int exp_lat, input string name);
        int lat, low, w;
        w = 0;
        while (!ir[u] && w < 50) begin tick(); w++; end
        chk({name, " ready_wait"}, 128'(w < 50), 128'(1));
        iv[u] = 1'b1;
        din   = d;
        tick();
        iv[u] = 1'b0;
        din   = {$urandom, $urandom, $urandom, $urandom};
        lat = 0; low = 0;
        while (!ov[u] && lat < 30) begin
            if (!ir[u]) low++;
            tick();
            lat++;
        end
        if (!ir[u]) low++;
        chk({name, " latency"}, 128'(lat), 128'(exp_lat));
        chk({name, " dout"}, dsel(u), e);
        chk({name, " ready_low_cycles"}, 128'(low), 128'(exp_lat + 1));
        tick();
        chk({name, " valid_pulse"}, 128'(ov[u]), 128'(0));
        chk({name, " ready_back"}, 128'(ir[u]), 128'(1));
    endtask

    initial begin
        logic [127:0] hold_val, st, got, src;
        int  w, idx, results, cyc, last_cyc;
        bit  will_accept, bad;

        n_checks = 0; n_fail = 0;
        iv = 3'b000; din = '0; ordy = 1'b1; rst = 1'b1;

        vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6,
                    128'hdb135345_f20a225c_01010101_d4d4d4d5, "fips"};
        vecs[1] = '{128'h4d7ebdf8_c6c6c6c6_8e4da1bc_00000000,
                    128'h2d26314c_c6c6c6c6_db135345_00000000, "round_trip"};
        vecs[2] = '{128'h01000000_00000001_80000000_ffffffff,
                    128'h0e090d0b_090d0b0e_41ecdaf7_ffffffff, "single_bytes"};

        // reset state
        tick(); tick();
        chk("rst in_ready", 128'(ir), 128'(0));
        chk("rst out_valid", 128'(ov), 128'(0));
        chk("rst dout", dout0 | dout1 | dout2, 128'h0);
        chk("rst state", 128'({dbg0, dbg1, dbg2}), 128'(0));
        @(negedge clk); rst = 1'b0;
        tick();
        chk("first clk in_ready", 128'(ir), 128'(3'b111));

        // latency for each width
        run_vec(0, vecs[0].din, vecs[0].exp, 4, "c1 fips");
        run_vec(1, vecs[0].din, vecs[0].exp, 2, "c2 fips");
        run_vec(2, vecs[0].din, vecs[0].exp, 1, "c4 fips");

        for (int i = 0; i < 3; i++) begin
            run_vec(0, vecs[i].din, vecs[i].exp, 4, {"tbl ", vecs[i].name});
            run_vec(2, vecs[i].din, vecs[i].exp, 1, {"tbl4 ", vecs[i].name});
        end

        // backpressure
        ordy = 1'b0;
        iv[0] = 1'b1; din = vecs[1].din;
        tick();
        iv[0] = 1'b0;
        w = 0;
        while (!ov[0] && w < 30) begin tick(); w++; end
        chk("bp reach_done", 128'(ov[0]), 128'(1));
        hold_val = dout0;
        chk("bp dout", hold_val, vecs[1].exp);
        for (int i = 0; i < 10; i++) begin
            iv[0] = (i == 3);
            din   = vecs[2].din;
            tick();
            chk("bp hold valid", 128'(ov[0]), 128'(1));
            chk("bp hold dout", dout0, vecs[1].exp);
            chk("bp hold ready", 128'(ir[0]), 128'(0));
        end
        iv[0] = 1'b0;
        ordy = 1'b1;
        tick();
        chk("bp release valid", 128'(ov[0]), 128'(0));
        chk("bp release ready", 128'(ir[0]), 128'(1));
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); if (ov[0] || !ir[0]) bad = 1'b1; end
        chk("bp no_second_accept", 128'(bad), 128'(0));

        // asynchronous reset in the second CALC cycle
        iv[0] = 1'b1; din = vecs[2].din;
        tick();
        iv[0] = 1'b0;
        tick();
        #3 rst = 1'b1;
        #1;
        chk("mid_rst out_valid", 128'(ov[0]), 128'(0));
        chk("mid_rst dout", dout0, 128'h0);
        chk("mid_rst in_ready", 128'(ir[0]), 128'(0));
        tick();
        @(negedge clk); rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); if (ov[0]) bad = 1'b1; end
        chk("mid_rst no_stale", 128'(bad), 128'(0));
        run_vec(0, vecs[0].din, vecs[0].exp, 4, "after_rst");

        // back-to-back with scoreboard
        idx = 0; results = 0; cyc = 0; last_cyc = 0;
        st = {$urandom, $urandom, $urandom, $urandom};
        iv[0] = 1'b1; din = st;
        while (results < 3 && cyc < 200) begin
            will_accept = iv[0] && ir[0];
            tick();
            cyc++;
            if (will_accept) begin
                in_q.push_back(din);
                exp_q.push_back(model_col_mix(din, 1'b1));
                idx++;
                if (idx < 3) din = {$urandom, $urandom, $urandom, $urandom};
                else         iv[0] = 1'b0;
            end
            if (ov[0]) begin
                got = exp_q.pop_front();
                src = in_q.pop_front();
                chk("b2b dout", dout0, got);
                chk("b2b mix_back", model_col_mix(dout0, 1'b0), src);
                if (results > 0) chk("b2b spacing", 128'(cyc - last_cyc), 128'(6));
                last_cyc = cyc;
                results++;
            end
        end
        chk("b2b result_count", 128'(results), 128'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
